// File: rtl/p_alu_serial_if.sv
// Request/response bundle for the bit-serial ALU: operands and op select in,
// handshake, result and flags out.
interface p_alu_serial_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       sel;
  logic             acc_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  modport master (
    output start, a, b, cin, sel, acc_en,
    input  busy, done, result, carry, zero
  );

  modport slave (
    input  start, a, b, cin, sel, acc_en,
    output busy, done, result, carry, zero
  );
endinterface

// File: rtl/p_alu_serial.sv
// Bit-serial ALU (ADD/SUB/AND/OR) built around one controlled full-adder slice,
// one operand bit per clock, LSB first, with accumulate mode and carry/zero flags.
module p_alu_serial #(
  parameter int WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  p_alu_serial_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       sel_q, sel_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic             bit_a;
  logic             bit_b;
  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] res_shift;

  // Single controlled full-adder slice; SUB inverts the B bit, the carry
  // preload supplies the +1 of the two's complement.
  always_comb begin
    bit_a      = a_q[0];
    bit_b      = b_q[0] ^ (sel_q == OP_SUB);
    sum_bit    = 1'b0;
    carry_next = 1'b0;
    case (sel_q)
      OP_ADD, OP_SUB: begin
        sum_bit    = bit_a ^ bit_b ^ c_q;
        carry_next = (bit_a & bit_b) | (bit_a & c_q) | (bit_b & c_q);
      end
      OP_AND: sum_bit = bit_a & bit_b;
      OP_OR:  sum_bit = bit_a | bit_b;
      default: begin
        sum_bit    = 1'b0;
        carry_next = 1'b0;
      end
    endcase
    res_shift = {sum_bit, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sel_q   <= OP_ADD;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sel_q   <= sel_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sel_d   = sel_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Accumulate chains the held result in place of operand A.
          a_d     = bus.acc_en ? res_q : bus.a;
          b_d     = bus.b;
          sel_d   = bus.sel;
          c_d     = bus.sel[1] ? 1'b0 : bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        c_d   = carry_next;
        res_d = res_shift;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_BIT) begin
          carry_d = carry_next;
          zero_d  = (res_shift == '0);
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q == RUN) || (state_q == DONE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = res_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_p_alu_serial.sv
// Bench for p_alu_serial at WIDTH=5 and WIDTH=8: arithmetic reference model,
// per-cycle output comparison, directed literal checks and randomized ops.
module tb_p_alu_serial;
  logic clk = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;

  int cmp_cnt = 0;
  int err_cnt = 0;

  p_alu_serial_if #(.WIDTH(5)) if5 ();
  p_alu_serial_if #(.WIDTH(8)) if8 ();

  p_alu_serial #(.WIDTH(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));
  p_alu_serial #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  always #5 clk = ~clk;

  // Model state: cycles of busy remaining, committed outputs, pending outputs.
  int m_ph   [2] = '{0, 0};
  int m_res  [2] = '{0, 0};
  int m_car  [2] = '{0, 0};
  int m_zero [2] = '{1, 1};
  int p_res  [2] = '{0, 0};
  int p_car  [2] = '{0, 0};

  task automatic check(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic calc(input int w, input int s, input int av, input int bv, input int ci,
                      output int r, output int co);
    int mask;
    int t;
    mask = (1 << w) - 1;
    case (s)
      0:       t = av + bv + ci;
      1:       t = av + ((~bv) & mask) + ci;
      2:       t = av & bv;
      default: t = av | bv;
    endcase
    r  = t & mask;
    co = (s < 2) ? ((t >> w) & 1) : 0;
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    int st, av, bv, ci, sl, ac, w, opa;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_ph[d] = 0; m_res[d] = 0; m_car[d] = 0; m_zero[d] = 1;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        w  = (d == 1) ? 8 : 5;
        st = (d == 1) ? int'(if8.start)  : int'(if5.start);
        av = (d == 1) ? int'(if8.a)      : int'(if5.a);
        bv = (d == 1) ? int'(if8.b)      : int'(if5.b);
        ci = (d == 1) ? int'(if8.cin)    : int'(if5.cin);
        sl = (d == 1) ? int'(if8.sel)    : int'(if5.sel);
        ac = (d == 1) ? int'(if8.acc_en) : int'(if5.acc_en);
        if (m_ph[d] > 0) begin
          m_ph[d]--;
          if (m_ph[d] == 1) begin
            m_res[d]  = p_res[d];
            m_car[d]  = p_car[d];
            m_zero[d] = (p_res[d] == 0) ? 1 : 0;
          end
        end else if (st == 1) begin
          opa = (ac == 1) ? m_res[d] : av;
          calc(w, sl, opa, bv, ci, p_res[d], p_car[d]);
          m_ph[d] = w + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int ab, ad, ar, ac, az;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        ab = (d == 1) ? int'(if8.busy)   : int'(if5.busy);
        ad = (d == 1) ? int'(if8.done)   : int'(if5.done);
        ar = (d == 1) ? int'(if8.result) : int'(if5.result);
        ac = (d == 1) ? int'(if8.carry)  : int'(if5.carry);
        az = (d == 1) ? int'(if8.zero)   : int'(if5.zero);
        check($sformatf("busy[w%0d]", d ? 8 : 5), ab, (m_ph[d] != 0) ? 1 : 0);
        check($sformatf("done[w%0d]", d ? 8 : 5), ad, (m_ph[d] == 1) ? 1 : 0);
        if (m_ph[d] <= 1) begin
          check($sformatf("result[w%0d]", d ? 8 : 5), ar, m_res[d]);
          check($sformatf("carry[w%0d]", d ? 8 : 5), ac, m_car[d]);
          check($sformatf("zero[w%0d]", d ? 8 : 5), az, m_zero[d]);
        end
      end
    end
  end

  task automatic drive(input int d, input int st, input int s, input int av, input int bv,
                       input int ci, input int ac);
    if (d == 1) begin
      if8.start = 1'(st); if8.sel = 2'(s); if8.a = 8'(av); if8.b = 8'(bv);
      if8.cin = 1'(ci); if8.acc_en = 1'(ac);
    end else begin
      if5.start = 1'(st); if5.sel = 2'(s); if5.a = 5'(av); if5.b = 5'(bv);
      if5.cin = 1'(ci); if5.acc_en = 1'(ac);
    end
  endtask

  // mode 0: plain, 1: noisy inputs and stray starts, 2: one stray start at
  // cycle 2, 3: asynchronous reset at counter=2 (returns without done).
  task automatic run_op(input int d, input int s, input int av, input int bv, input int ci,
                        input int ac, input int mode,
                        output int res, output int co, output int z, output int cyc);
    int got;
    @(negedge clk);
    drive(d, 1, s, av, bv, ci, ac);
    cyc = 0; got = 0; res = 0; co = 0; z = 0;
    while (got == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mode == 3 && cyc == 3) begin
        drive(d, 0, s, av, bv, ci, ac);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", (d == 1) ? int'(if8.busy)   : int'(if5.busy),   0);
        check("rst_done", (d == 1) ? int'(if8.done)   : int'(if5.done),   0);
        check("rst_result", (d == 1) ? int'(if8.result) : int'(if5.result), 0);
        check("rst_carry", (d == 1) ? int'(if8.carry)  : int'(if5.carry),  0);
        check("rst_zero", (d == 1) ? int'(if8.zero)   : int'(if5.zero),   1);
        $display("op w=%0d sel=%0d a=%0d b=%0d reset mid-run", d ? 8 : 5, s, av, bv);
        return;
      end
      if (((d == 1) ? if8.done : if5.done) == 1'b1) begin
        got = 1;
        res = (d == 1) ? int'(if8.result) : int'(if5.result);
        co  = (d == 1) ? int'(if8.carry)  : int'(if5.carry);
        z   = (d == 1) ? int'(if8.zero)   : int'(if5.zero);
        drive(d, 0, s, av, bv, ci, ac);
      end else if (mode == 1) begin
        drive(d, ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 3)),
              int'($urandom), int'($urandom), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)));
      end else if (mode == 2 && cyc == 2) begin
        drive(d, 1, 1, 5, 6, 0, 0);
      end else begin
        drive(d, 0, s, av, bv, ci, ac);
      end
    end
    if (got == 0) check("done_timeout", 0, 1);
    $display("op w=%0d sel=%0d a=%0d b=%0d cin=%0d acc=%0d -> result=%0d carry=%0d zero=%0d cycles=%0d",
             d ? 8 : 5, s, av, bv, ci, ac, res, co, z, cyc);
  endtask

  initial begin : stim
    int r, c, z, n;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_result", int'(if5.result), 0);
    check("reset_zero", int'(if5.zero), 1);
    check("reset_busy", int'(if5.busy), 0);
    rst_n = 1'b1;

    run_op(0, 0, 13, 9, 0, 0, 0, r, c, z, n);
    check("add13_9", r, 22); check("add13_9_c", c, 0); check("add13_9_z", z, 0);
    check("add13_9_latency", n, 6);
    run_op(0, 0, 31, 1, 0, 0, 0, r, c, z, n);
    check("add31_1", r, 0); check("add31_1_c", c, 1); check("add31_1_z", z, 1);
    run_op(0, 1, 9, 13, 1, 0, 0, r, c, z, n);
    check("sub9_13", r, 28); check("sub9_13_c", c, 0);
    run_op(0, 2, 22, 15, 0, 0, 0, r, c, z, n);
    check("and", r, 6); check("and_c", c, 0);
    run_op(0, 3, 22, 15, 1, 0, 0, r, c, z, n);
    check("or", r, 31); check("or_z", z, 0); check("or_c", c, 0);

    run_op(0, 0, 7, 5, 0, 0, 0, r, c, z, n);
    check("acc_seed", r, 12);
    run_op(0, 0, 0, 3, 0, 1, 0, r, c, z, n);
    check("acc_add", r, 15);
    run_op(0, 1, 0, 15, 1, 1, 0, r, c, z, n);
    check("acc_sub", r, 0); check("acc_sub_z", z, 1);

    run_op(0, 0, 10, 11, 0, 0, 2, r, c, z, n);
    check("ignored_start", r, 21); check("ignored_start_lat", n, 6);
    run_op(0, 0, 1, 2, 0, 0, 0, r, c, z, n);
    check("start_after_done", r, 3); check("start_after_done_lat", n, 6);

    run_op(0, 0, 12, 17, 0, 0, 3, r, c, z, n);
    @(negedge clk);
    check("held_in_reset", int'(if5.busy), 0);
    rst_n = 1'b1;
    run_op(0, 0, 3, 4, 0, 0, 0, r, c, z, n);
    check("post_reset_add", r, 7); check("post_reset_lat", n, 6);

    run_op(1, 0, 200, 100, 0, 0, 0, r, c, z, n);
    check("w8_add", r, 44); check("w8_add_c", c, 1); check("w8_lat", n, 9);
    run_op(1, 1, 100, 200, 1, 0, 0, r, c, z, n);
    check("w8_sub", r, 156); check("w8_sub_c", c, 0);
    run_op(1, 0, 255, 1, 0, 0, 0, r, c, z, n);
    check("w8_wrap", r, 0); check("w8_wrap_z", z, 1);

    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(i % 2, int'($urandom_range(0, 3)), int'($urandom), int'($urandom),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1, r, c, z, n);
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
